// File: rtl/synth_pkg.sv
// synth_pkg: shared constants, types and note-to-phase-step table for the voice synthesizer.
package synth_pkg;
  localparam int STEP_W = 24;
  localparam int NUM_NOTES = 48;
  localparam int SAMPLE_HZ = 48000;
  typedef logic [STEP_W-1:0] step_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic step_t calc_step(input int n);
    real f;
    f = 261.63 * (2.0 ** (real'(n) / 12.0)) * (2.0 ** STEP_W) / real'(SAMPLE_HZ);
    return step_t'($rtoi(f + 0.5));
  endfunction
  localparam step_t NOTE_STEP [NUM_NOTES] = '{
    calc_step(0),  calc_step(1),  calc_step(2),  calc_step(3),  calc_step(4),  calc_step(5),
    calc_step(6),  calc_step(7),  calc_step(8),  calc_step(9),  calc_step(10), calc_step(11),
    calc_step(12), calc_step(13), calc_step(14), calc_step(15), calc_step(16), calc_step(17),
    calc_step(18), calc_step(19), calc_step(20), calc_step(21), calc_step(22), calc_step(23),
    calc_step(24), calc_step(25), calc_step(26), calc_step(27), calc_step(28), calc_step(29),
    calc_step(30), calc_step(31), calc_step(32), calc_step(33), calc_step(34), calc_step(35),
    calc_step(36), calc_step(37), calc_step(38), calc_step(39), calc_step(40), calc_step(41),
    calc_step(42), calc_step(43), calc_step(44), calc_step(45), calc_step(46), calc_step(47)
  };
endpackage

// File: rtl/note_step_lut.sv
// note_step_lut: combinational note number to phase step lookup with out-of-range flag.
module note_step_lut
  import synth_pkg::*;
(
  input  logic [7:0] note,
  output step_t      step,
  output logic       oor
);
  always_comb begin
    oor = note >= 8'(NUM_NOTES);
    step = '0;
    for (int i = 0; i < NUM_NOTES; i++) step = (note == 8'(i)) ? NOTE_STEP[i] : step;
  end
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: time-multiplexes one wave ROM across NUM_VOICES phase accumulators and mixes them.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W = 24,
  parameter int ADDR_W = 8,
  parameter int SAMPLE_W = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sample_tick,
  input  logic [NUM_VOICES-1:0]                   voice_en,
  input  logic [NUM_VOICES*8-1:0]                 voice_note,
  output logic [ADDR_W-1:0]                       rom_addr,
  input  logic [SAMPLE_W-1:0]                     rom_data,
  output logic [SAMPLE_W+$clog2(NUM_VOICES)-1:0]  mix_out,
  output logic                                    mix_valid,
  output logic                                    busy,
  output logic                                    overrun
);
  localparam int IDX_W = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int MIX_W = SAMPLE_W + $clog2(NUM_VOICES);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [MIX_W-1:0] acc_q, acc_d, mix_q, mix_d, add;
  logic mix_valid_q, mix_valid_d, prev_valid_q, prev_valid_d;
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];
  step_t cur_step;
  logic cur_oor, cur_valid;
  note_step_lut u_lut (
    .note(voice_note[8*idx_q +: 8]),
    .step(cur_step),
    .oor (cur_oor)
  );
  assign cur_valid = voice_en[idx_q] && !cur_oor;
  assign add = prev_valid_q ? MIX_W'(rom_data) : '0;
  assign rom_addr = (state_q == RUN) ? phase_q[idx_q][PHASE_W-1 -: ADDR_W] : '0;
  assign busy = state_q != IDLE;
  assign overrun = sample_tick && busy;
  assign mix_out = mix_q;
  assign mix_valid = mix_valid_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    mix_d = mix_q;
    mix_valid_d = 1'b0;
    prev_valid_d = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) phase_d[i] = voice_en[i] ? phase_q[i] : '0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        acc_d = sample_tick ? '0 : acc_q;
        state_d = sample_tick ? RUN : IDLE;
      end
      RUN: begin
        phase_d[idx_q] = cur_valid ? phase_q[idx_q] + PHASE_W'(cur_step) : phase_d[idx_q];
        acc_d = acc_q + add;
        prev_valid_d = cur_valid;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == IDX_W'(NUM_VOICES - 1)) ? DRAIN : RUN;
      end
      default: begin
        mix_d = acc_q + add;
        mix_valid_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      mix_q <= '0;
      mix_valid_q <= 1'b0;
      prev_valid_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      mix_q <= mix_d;
      mix_valid_q <= mix_valid_d;
      prev_valid_q <= prev_valid_d;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= phase_d[i];
    end
  end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed and randomized sweeps checked against a per-voice phase/mix model.
module tb_voice_scheduler;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic [N-1:0] voice_en = '0;
  logic [N*8-1:0] voice_note = '0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [9:0] mix_out;
  logic mix_valid, busy, overrun;
  bit rom_const = 1'b0;
  int checks = 0;
  int errs = 0;
  int unsigned ph [N];
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_const ? 8'hFF : rom_addr;
  voice_scheduler #(.NUM_VOICES(N), .PHASE_W(24), .ADDR_W(8), .SAMPLE_W(8)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .voice_en(voice_en),
    .voice_note(voice_note), .rom_addr(rom_addr), .rom_data(rom_data),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );
  function automatic int unsigned step_of(input int n);
    return int'($rtoi(261.63 * $pow(2.0, n / 12.0) * 16777216.0 / 48000.0 + 0.5));
  endfunction
  function automatic int note_of(input int i);
    return int'(voice_note[8*i +: 8]);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_cfg(input logic [N-1:0] en, input logic [N*8-1:0] notes);
    voice_en = en;
    voice_note = notes;
    for (int i = 0; i < N; i++) if (!en[i]) ph[i] = 0;
    cyc();
  endtask
  task automatic sweep(input int ovr_at, input string tag);
    int unsigned exp_mix;
    exp_mix = 0;
    cyc();
    sample_tick = 1'b1;
    #2;
    chk({tag, " busy c0"}, busy, 0);
    chk({tag, " overrun c0"}, overrun, 0);
    cyc();
    for (int c = 1; c <= N + 3; c++) begin
      if (c > 1) cyc();
      sample_tick = (c == ovr_at);
      #2;
      if (c <= N) begin
        chk({tag, " rom_addr"}, rom_addr, (ph[c-1] >> 16) & 8'hFF);
        if (voice_en[c-1] && note_of(c-1) < 48) begin
          exp_mix += rom_const ? 255 : ((ph[c-1] >> 16) & 8'hFF);
          ph[c-1] = (ph[c-1] + step_of(note_of(c-1))) & 24'hFFFFFF;
        end
      end
      chk({tag, " busy"}, busy, c <= N + 1);
      chk({tag, " overrun"}, overrun, c == ovr_at && c <= N + 1);
      chk({tag, " mix_valid"}, mix_valid, c == N + 2);
      if (c == N + 2) chk({tag, " mix_out"}, mix_out, exp_mix);
    end
    sample_tick = 1'b0;
  endtask
  initial begin
    logic [N*8-1:0] notes;
    int unsigned s0;
    for (int i = 0; i < N; i++) ph[i] = 0;
    s0 = step_of(0);
    cyc();
    cyc();
    #2;
    chk("reset mix_out", mix_out, 0);
    chk("reset mix_valid", mix_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset rom_addr", rom_addr, 0);
    rst = 1'b0;
    sweep(0, "t1 all off");
    set_cfg(4'b0001, '0);
    for (int k = 0; k < 3; k++) begin
      sweep(0, "t2 voice0");
      chk("t2 ramp mix", mix_out, ((k * s0) >> 16) & 8'hFF);
      repeat (20 - (N + 4)) cyc();
    end
    rom_const = 1'b1;
    set_cfg(4'b1111, {4{8'd12}});
    sweep(0, "t3 const rom");
    chk("t3 full scale", mix_out, 1020);
    rom_const = 1'b0;
    set_cfg(4'b1111, {8'd7, 8'd30, 8'd47, 8'd2});
    sweep(3, "t4 overrun");
    sweep(0, "t4 after");
    set_cfg(4'b0000, '0);
    set_cfg(4'b1111, {8'd20, 8'd33, 8'd60, 8'd5});
    for (int k = 0; k < 5; k++) sweep(0, "t5 bad note");
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < N; i++) ph[i] = 0;
    for (int c = 4; c <= 10; c++) begin
      #2;
      chk("t6 mix_valid", mix_valid, 0);
      chk("t6 busy", busy, 0);
      chk("t6 overrun", overrun, 0);
      chk("t6 mix_out", mix_out, 0);
      chk("t6 rom_addr", rom_addr, 0);
      cyc();
    end
    sweep(0, "t6 after rst");
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) notes[8*i +: 8] = 8'($urandom_range(0, 55));
      rom_const = ($urandom_range(0, 3) == 0);
      set_cfg(4'($urandom_range(0, 15)), notes);
      for (int r = 0; r < 3; r++) sweep(($urandom_range(0, 9) < 3) ? int'($urandom_range(1, N + 1)) : 0, "rand");
      repeat ($urandom_range(0, 3)) cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
